// File: rtl/dm_responder.sv
// Data-memory responder: serves CPU loads/stores from a word array after a programmable latency.
// Latency LAT+1 stalled cycles then one DONE cycle; DM_stall holds the CPU request while an access is in flight.
module dm_responder #(
  parameter int DEPTH     = 16384,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_WEB,
  input  logic        DM_write,
  input  logic [3:0]  DM_BWEB,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_DI,
  output logic [31:0] DM_DO,
  output logic        DM_stall,
  output logic        dm_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXL = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          store_q, both_q, oor_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   di_q;
  logic [3:0]    bweb_q;
  logic [31:0]   do_q, do_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH];

  logic          req, in_oor, cap_en, acc_en, stall;
  logic [AW-1:0] in_idx;
  logic          acc_store, acc_both, acc_oor;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_di;
  logic [3:0]    acc_bweb;
  logic          mem_we;
  int            lat;
  logic          unused_addr_lsb;

  assign req             = DM_WEB | DM_write;
  assign in_oor          = |(DM_addr >> (AW + 2));
  assign in_idx          = DM_addr[AW+1:2];
  assign unused_addr_lsb = &{1'b0, DM_addr[1:0]};

  // A zero-latency access completes straight out of IDLE, so it must use the live inputs.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_store = DM_write;
      acc_both  = DM_WEB & DM_write;
      acc_oor   = in_oor;
      acc_idx   = in_idx;
      acc_di    = DM_DI;
      acc_bweb  = DM_BWEB;
    end else begin
      acc_store = store_q;
      acc_both  = both_q;
      acc_oor   = oor_q;
      acc_idx   = idx_q;
      acc_di    = di_q;
      acc_bweb  = bweb_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    cap_en  = 1'b0;
    acc_en  = 1'b0;
    lat     = DM_write ? WRITE_LAT : READ_LAT;
    case (state_q)
      S_IDLE: begin
        stall = req;
        if (req) begin
          cap_en = 1'b1;
          if (lat == 0) begin
            acc_en  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d   = CW'(lat - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          acc_en  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and the array write are gated by reset so a request held during reset has no effect.
  assign DM_stall = stall & rst;
  assign mem_we   = acc_en & rst & acc_store & ~acc_oor;
  assign do_d     = (acc_en && !acc_store) ? (acc_oor ? 32'h0 : mem_q[acc_idx]) : do_q;
  assign err_d    = err_q | (acc_en & (acc_oor | acc_both));
  assign DM_DO    = do_q;
  assign dm_err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      store_q <= 1'b0;
      both_q  <= 1'b0;
      oor_q   <= 1'b0;
      idx_q   <= '0;
      di_q    <= '0;
      bweb_q  <= 4'hF;
      do_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      do_q    <= do_d;
      err_q   <= err_d;
      if (cap_en) begin
        store_q <= DM_write;
        both_q  <= DM_WEB & DM_write;
        oor_q   <= in_oor;
        idx_q   <= in_idx;
        di_q    <= DM_DI;
        bweb_q  <= DM_BWEB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (!acc_bweb[i]) mem_q[acc_idx][8*i +: 8] <= acc_di[8*i +: 8];
      end
    end
  end

endmodule
